// File: rtl/race_round_sequencer.sv
// Match controller for the two-lane LED race: round sequencing, scoring and
// round-robin arbitration of the shared speed-boost between motor and car.
module race_round_sequencer #(
  parameter int COUNT_START = 3,
  parameter int WIN_SCORE   = 3,
  parameter int BOOST_TICKS = 4,
  parameter int BOOST_LIMIT = 2,
  parameter int END_HOLD    = 2
) (
  input  logic       myclk27,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic       m_finish,
  input  logic       c_finish,
  input  logic       m_boost_req,
  input  logic       c_boost_req,
  output logic       race_en,
  output logic       round_rst,
  output logic       m_boost,
  output logic       c_boost,
  output logic [1:0] m_score,
  output logic [1:0] c_score,
  output logic [2:0] countdown,
  output logic [1:0] winner
);

  localparam logic [2:0] CNT_INIT   = 3'(COUNT_START);
  localparam logic [1:0] WIN_L      = 2'(WIN_SCORE);
  localparam logic [2:0] BOOST_L    = 3'(BOOST_TICKS);
  localparam logic [1:0] LIMIT_L    = 2'(BOOST_LIMIT);
  localparam logic [2:0] HOLD_L     = 3'(END_HOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_RACE,
    S_ROUND_END,
    S_MATCH_END
  } state_t;

  state_t     state_reg;
  logic [2:0] hold_cnt_reg;
  logic [2:0] boost_cnt_reg;
  logic [1:0] m_budget_reg;
  logic [1:0] c_budget_reg;
  logic       rr_car_reg;

  logic       in_race;
  logic       race_exit;
  logic       match_go;
  logic       budget_refill;
  logic       grant_active;
  logic       m_eligible;
  logic       c_eligible;
  logic [1:0] m_score_inc;
  logic [1:0] c_score_inc;

  assign in_race       = (state_reg == S_RACE);
  assign race_exit     = in_race && (m_finish || c_finish);
  assign match_go      = start && ((state_reg == S_IDLE) || (state_reg == S_MATCH_END));
  assign budget_refill = match_go || ((state_reg == S_ROUND_END) && (hold_cnt_reg == 3'd1));
  assign grant_active  = m_boost || c_boost;
  assign m_eligible    = m_boost_req && (m_budget_reg != 2'd0);
  assign c_eligible    = c_boost_req && (c_budget_reg != 2'd0);
  assign m_score_inc   = m_score + 2'd1;
  assign c_score_inc   = c_score + 2'd1;

  // Round sequencing, scoring and the registered datapath controls.
  always_ff @(posedge myclk27 or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      hold_cnt_reg <= 3'd0;
      countdown    <= 3'd0;
      m_score      <= 2'd0;
      c_score      <= 2'd0;
      winner       <= 2'b00;
      race_en      <= 1'b0;
      round_rst    <= 1'b1;
    end else if (en) begin
      case (state_reg)
        S_IDLE, S_MATCH_END: begin
          if (start) begin
            state_reg <= S_COUNTDOWN;
            countdown <= CNT_INIT;
            m_score   <= 2'd0;
            c_score   <= 2'd0;
            winner    <= 2'b00;
            race_en   <= 1'b0;
            round_rst <= 1'b1;
          end
        end

        S_COUNTDOWN: begin
          if (countdown == 3'd1) begin
            state_reg <= S_RACE;
            countdown <= 3'd0;
            race_en   <= 1'b1;
            round_rst <= 1'b0;
          end else begin
            countdown <= countdown - 3'd1;
          end
        end

        S_RACE: begin
          if (m_finish || c_finish) begin
            race_en      <= 1'b0;
            round_rst    <= 1'b1;
            hold_cnt_reg <= HOLD_L;
            state_reg    <= S_ROUND_END;
            if (m_finish && !c_finish) begin
              m_score <= m_score_inc;
              if (m_score_inc == WIN_L) begin
                state_reg <= S_MATCH_END;
                winner    <= 2'b01;
              end
            end else if (c_finish && !m_finish) begin
              c_score <= c_score_inc;
              if (c_score_inc == WIN_L) begin
                state_reg <= S_MATCH_END;
                winner    <= 2'b10;
              end
            end
          end
        end

        S_ROUND_END: begin
          if (hold_cnt_reg == 3'd1) begin
            state_reg    <= S_COUNTDOWN;
            countdown    <= CNT_INIT;
            hold_cnt_reg <= 3'd0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg - 3'd1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          race_en   <= 1'b0;
          round_rst <= 1'b1;
        end
      endcase
    end
  end

  // Boost arbiter: arbitrates only while no grant is up, so the cycle that
  // drops a grant is always followed by at least one idle tick.
  always_ff @(posedge myclk27 or posedge rst) begin
    if (rst) begin
      m_boost       <= 1'b0;
      c_boost       <= 1'b0;
      boost_cnt_reg <= 3'd0;
      m_budget_reg  <= LIMIT_L;
      c_budget_reg  <= LIMIT_L;
      rr_car_reg    <= 1'b0;
    end else if (en) begin
      if (budget_refill) begin
        m_budget_reg <= LIMIT_L;
        c_budget_reg <= LIMIT_L;
      end

      if (!in_race || race_exit) begin
        m_boost       <= 1'b0;
        c_boost       <= 1'b0;
        boost_cnt_reg <= 3'd0;
      end else if (grant_active) begin
        if (boost_cnt_reg == 3'd1) begin
          m_boost       <= 1'b0;
          c_boost       <= 1'b0;
          boost_cnt_reg <= 3'd0;
        end else begin
          boost_cnt_reg <= boost_cnt_reg - 3'd1;
        end
      end else if (m_eligible && (!c_eligible || !rr_car_reg)) begin
        m_boost       <= 1'b1;
        boost_cnt_reg <= BOOST_L;
        m_budget_reg  <= m_budget_reg - 2'd1;
        rr_car_reg    <= 1'b1;
      end else if (c_eligible) begin
        c_boost       <= 1'b1;
        boost_cnt_reg <= BOOST_L;
        c_budget_reg  <= c_budget_reg - 2'd1;
        rr_car_reg    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_race_round_sequencer.sv
// Directed bench for race_round_sequencer with default parameters.
module tb_race_round_sequencer;

  logic       myclk27 = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       start = 1'b0;
  logic       m_finish = 1'b0;
  logic       c_finish = 1'b0;
  logic       m_boost_req = 1'b0;
  logic       c_boost_req = 1'b0;
  logic       race_en;
  logic       round_rst;
  logic       m_boost;
  logic       c_boost;
  logic [1:0] m_score;
  logic [1:0] c_score;
  logic [2:0] countdown;
  logic [1:0] winner;

  int n_checks = 0;
  int n_errors = 0;

  race_round_sequencer dut (
    .myclk27    (myclk27),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .m_finish   (m_finish),
    .c_finish   (c_finish),
    .m_boost_req(m_boost_req),
    .c_boost_req(c_boost_req),
    .race_en    (race_en),
    .round_rst  (round_rst),
    .m_boost    (m_boost),
    .c_boost    (c_boost),
    .m_score    (m_score),
    .c_score    (c_score),
    .countdown  (countdown),
    .winner     (winner)
  );

  always #5 myclk27 = ~myclk27;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge myclk27);
    #1;
  endtask

  // Entered COUNTDOWN on the previous edge: expect 3,2,1 then RACE.
  task automatic run_to_race(input string tag);
    check_val({tag, "_cd3"}, int'(countdown), 3);
    check_val({tag, "_cd_rrst"}, int'(round_rst), 1);
    tick();
    check_val({tag, "_cd2"}, int'(countdown), 2);
    tick();
    check_val({tag, "_cd1"}, int'(countdown), 1);
    tick();
    check_val({tag, "_race_en"}, int'(race_en), 1);
    check_val({tag, "_race_rrst"}, int'(round_rst), 0);
    check_val({tag, "_race_cd"}, int'(countdown), 0);
    $display("round %s: race started", tag);
  endtask

  // Entered ROUND_END on the previous edge: two hold ticks, then reload.
  task automatic end_hold(input string tag);
    check_val({tag, "_hold1_cd"}, int'(countdown), 0);
    check_val({tag, "_hold1_race"}, int'(race_en), 0);
    tick();
    check_val({tag, "_hold2_cd"}, int'(countdown), 0);
    check_val({tag, "_hold2_rrst"}, int'(round_rst), 1);
    tick();
  endtask

  task automatic finish_edge(input logic mf, input logic cf);
    m_finish = mf;
    c_finish = cf;
    tick();
    m_finish = 1'b0;
    c_finish = 1'b0;
    $display("finish m=%0b c=%0b -> score %0d:%0d winner %0d", mf, cf, m_score, c_score, winner);
  endtask

  initial begin
    repeat (2) @(posedge myclk27);
    #1;
    check_val("rst_round_rst", int'(round_rst), 1);
    check_val("rst_race_en", int'(race_en), 0);
    check_val("rst_countdown", int'(countdown), 0);
    check_val("rst_winner", int'(winner), 0);
    check_val("rst_m_score", int'(m_score), 0);
    check_val("rst_c_score", int'(c_score), 0);
    check_val("rst_m_boost", int'(m_boost), 0);
    check_val("rst_c_boost", int'(c_boost), 0);
    rst = 1'b0;
    tick();
    check_val("idle_round_rst", int'(round_rst), 1);

    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_race("r1");

    finish_edge(1'b1, 1'b0);
    check_val("r1_m_score", int'(m_score), 1);
    check_val("r1_c_score", int'(c_score), 0);
    check_val("r1_winner", int'(winner), 0);
    end_hold("r1");
    run_to_race("r2");

    finish_edge(1'b1, 1'b1);
    check_val("tie_m_score", int'(m_score), 1);
    check_val("tie_c_score", int'(c_score), 0);
    check_val("tie_winner", int'(winner), 0);
    check_val("tie_round_rst", int'(round_rst), 1);
    end_hold("tie");
    run_to_race("r3");

    finish_edge(1'b0, 1'b1);
    check_val("r3_m_score", int'(m_score), 1);
    check_val("r3_c_score", int'(c_score), 1);
    end_hold("r3");
    run_to_race("r4");

    finish_edge(1'b1, 1'b0);
    check_val("r4_m_score", int'(m_score), 2);
    check_val("r4_winner", int'(winner), 0);
    end_hold("r4");
    run_to_race("r5");

    finish_edge(1'b1, 1'b0);
    check_val("win_m_score", int'(m_score), 3);
    check_val("win_winner", int'(winner), 1);
    check_val("win_round_rst", int'(round_rst), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("mend_winner", int'(winner), 1);
      check_val("mend_countdown", int'(countdown), 0);
      check_val("mend_race_en", int'(race_en), 0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("rematch_m_score", int'(m_score), 0);
    check_val("rematch_c_score", int'(c_score), 0);
    check_val("rematch_winner", int'(winner), 0);
    run_to_race("m2r1");

    // Both racers request continuously: M x4, idle, C x4, idle, M x4, idle, C x4, then budgets empty.
    m_boost_req = 1'b1;
    c_boost_req = 1'b1;
    for (int k = 0; k < 24; k++) begin
      logic exp_m;
      logic exp_c;
      tick();
      exp_m = (k <= 3) || (k >= 10 && k <= 13);
      exp_c = (k >= 5 && k <= 8) || (k >= 15 && k <= 18);
      check_val($sformatf("boost_m_k%0d", k), int'(m_boost), int'(exp_m));
      check_val($sformatf("boost_c_k%0d", k), int'(c_boost), int'(exp_c));
      $display("boost k=%0d m=%0b c=%0b", k, m_boost, c_boost);
    end
    m_boost_req = 1'b0;
    c_boost_req = 1'b0;

    finish_edge(1'b1, 1'b0);
    check_val("m2r1_m_score", int'(m_score), 1);
    end_hold("m2r1");
    run_to_race("m2r2");

    m_boost_req = 1'b1;
    tick();
    m_boost_req = 1'b0;
    check_val("frz_grant", int'(m_boost), 1);
    tick();
    check_val("frz_grant2", int'(m_boost), 1);
    en = 1'b0;
    m_finish = 1'b1;
    c_boost_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("frz_m_boost", int'(m_boost), 1);
      check_val("frz_c_boost", int'(c_boost), 0);
      check_val("frz_race_en", int'(race_en), 1);
      check_val("frz_m_score", int'(m_score), 1);
      $display("freeze tick %0d m_boost=%0b race_en=%0b", i, m_boost, race_en);
    end
    en = 1'b1;
    m_finish = 1'b0;
    c_boost_req = 1'b0;
    tick();
    check_val("resume_grant3", int'(m_boost), 1);
    tick();
    check_val("resume_grant4", int'(m_boost), 1);
    tick();
    check_val("resume_grant_end", int'(m_boost), 0);
    check_val("resume_race_en", int'(race_en), 1);
    m_boost_req = 1'b1;
    tick();
    check_val("regrant_m_boost", int'(m_boost), 1);

    #2 rst = 1'b1;
    #1;
    check_val("arst_m_boost", int'(m_boost), 0);
    check_val("arst_race_en", int'(race_en), 0);
    check_val("arst_round_rst", int'(round_rst), 1);
    check_val("arst_m_score", int'(m_score), 0);
    #2 rst = 1'b0;
    m_boost_req = 1'b0;
    tick();
    check_val("post_rst_race_en", int'(race_en), 0);
    check_val("post_rst_m_boost", int'(m_boost), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/race_round_sequencer.md
Name: race_round_sequencer

Overview:
Match controller for the two-lane LED race (motor lane vs car lane). It sequences each round (countdown, race, round-end hold, match-end) and keeps the match score. It arbitrates a single shared speed-boost resource between the two racers. It drives the racing datapath's enable and round-restart inputs and consumes that datapath's per-lane finish flags.

Parameters:
COUNT_START, 3, countdown ticks before each round (1..7)
WIN_SCORE, 3, round wins needed to take the match (1..3)
BOOST_TICKS, 4, ticks a boost grant stays asserted (1..7)
BOOST_LIMIT, 2, boost grants allowed per racer per round (0..3)
END_HOLD, 2, ticks spent in ROUND_END before the next countdown (1..7)

Ports:
myclk27  in  1  game tick clock (divided clock, one tick per step)
rst  in  1  reset, asynchronous, active-high
en  in  1  global pause; 0 = every register holds
start  in  1  level; starts a match from IDLE or MATCH_END
m_finish  in  1  motor reached the finish cell (level from datapath)
c_finish  in  1  car reached the finish cell (level from datapath)
m_boost_req  in  1  motor requests a boost
c_boost_req  in  1  car requests a boost
race_en  out  1  datapath advance enable
round_rst  out  1  datapath holds start positions while 1
m_boost  out  1  motor boost grant
c_boost  out  1  car boost grant
m_score  out  2  motor rounds won
c_score  out  2  car rounds won
countdown  out  3  remaining countdown ticks, 0 outside COUNTDOWN
winner  out  2  00 none, 01 motor, 10 car

Behaviour:
- Reset values: the FSM enters IDLE. All outputs are 0 except round_rst=1. Boost budgets are set to BOOST_LIMIT. The round-robin pointer is set so the motor wins the first tie. Reset asserted mid-operation forces this state at once, regardless of en.
- en=0: FSM, counters, scores, budgets and grants all hold their values. Outputs keep their current values. Finish and request inputs are ignored.
- All outputs are registered. Every decision below is sampled on a myclk27 edge with en=1.
- IDLE: race_en=0, round_rst=1. If start=1, go to COUNTDOWN on the next edge. On that edge, load countdown=COUNT_START, clear both scores, set winner=00 and refill both budgets.
- COUNTDOWN: race_en=0, round_rst=1. countdown decrements by 1 each tick. When countdown==1, go to RACE on the next edge and set countdown=0. COUNTDOWN therefore lasts exactly COUNT_START ticks.
- RACE: race_en=1, round_rst=0. Finish handling:
  - m_finish=1 with c_finish=0: m_score+1.
  - c_finish=1 with m_finish=0: c_score+1.
  - Both flags set on the same edge: tie; no score change; go to ROUND_END.
  - If the incremented score equals WIN_SCORE, go to MATCH_END and set winner; otherwise go to ROUND_END.
  - Both boost grants are cleared on the edge that leaves RACE.
- ROUND_END: race_en=0, round_rst=1. Hold for END_HOLD ticks. Then go to COUNTDOWN, reload countdown=COUNT_START and refill both budgets.
- MATCH_END: race_en=0, round_rst=1. Scores and winner hold. If start=1, behave exactly as start from IDLE. Otherwise stay in MATCH_END.
- start is ignored in COUNTDOWN, RACE and ROUND_END.
- Boost arbiter (active only in RACE):
  - At most one grant is asserted at any time.
  - A racer is eligible when its request is 1 and its budget is greater than 0.
  - Arbitration runs only on an edge where no grant is currently asserted.
  - One eligible racer: grant that racer. Two eligible racers: grant the racer not granted last, then update the round-robin pointer.
  - The grant asserts on the next edge and stays high for exactly BOOST_TICKS ticks. The racer's budget decrements on the grant edge.
  - Requests made while a grant is active are dropped, not queued. There is at least one idle tick between consecutive grants.
  - Budgets saturate at 0; a racer with budget 0 is never granted.
- Score width is 2 bits. WIN_SCORE ≤ 3 guarantees no wrap.

Test Plan:
- Defaults, rst then start=1 at tick 0 -> COUNTDOWN from tick 1 with countdown 3,2,1; RACE at tick 4; race_en=1 and round_rst=0 from tick 4.
- In RACE, m_finish pulse -> m_score=1, ROUND_END for 2 ticks, then countdown reloads to 3; c_score stays 0.
- m_finish and c_finish set on the same edge -> both scores unchanged, ROUND_END entered, no winner.
- Motor wins 3 rounds -> MATCH_END with winner=01 and m_score=3; start=1 -> scores clear and countdown=3.
- Both boost requests held continuously -> m_boost for 4 ticks, 1 idle tick, c_boost for 4 ticks, 1 idle tick, m_boost again, c_boost again; then no grants (both budgets 0).
- en=0 for 5 ticks mid-RACE with m_boost active -> all outputs frozen, grant resumes its remaining ticks after en=1; rst mid-grant -> IDLE and m_boost=0 immediately.
